// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one purely combinational 8-bit ALU between two requesting clients.
// One client is granted at a time, round-robin on contention. The granted
// client's operands and opcode are registered onto the ALU inputs. The ALU
// result is captured one cycle later and returned on a single response
// channel tagged with the owning client id. Requests are never queued: a
// client that is not granted keeps req_valid high and retries.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous, active-high reset
//   req_valid    in   2  per-client request valid (bit i = client i)
//   req_ready    out  2  per-client accept strobe (combinational)
//   req0_a/b     in   8  client 0 operands
//   req0_s       in   3  client 0 opcode
//   req1_a/b     in   8  client 1 operands
//   req1_s       in   3  client 1 opcode
//   alu_a/b      out  8  registered operands driven to the ALU
//   alu_s        out  3  registered opcode driven to the ALU
//   alu_z        in   8  ALU result, combinational from alu_a/alu_b/alu_s
//   rsp_valid    out  1  response valid (registered)
//   rsp_ready    in   1  response accept from the consumer
//   rsp_id       out  1  client that owns the response
//   rsp_z        out  8  captured ALU result
//   rsp_zero     out  1  high when rsp_z == 8'h00
// ---------------------------------------------------------------------------
module alu_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_s,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_s,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_z,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_z,
    output logic       rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_last_grant;
    logic       w_grant_vld;
    logic       w_grant_id;
    logic       w_hs;
    logic [1:0] w_req_ready;

    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_s;

    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_z;
    logic       r_rsp_zero;

    // Round-robin pick between the valid clients. On contention the client
    // that did not win last time is chosen. The result is only meaningful
    // when at least one bit of vld is set; callers qualify it with |vld.
    function automatic logic pick_grant(input logic [1:0] vld, input logic last);
        logic id;
        case (vld)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = ~last;
            default: id = 1'b0;
        endcase
        return id;
    endfunction

    assign w_grant_vld = |req_valid;
    assign w_grant_id  = pick_grant(req_valid, r_last_grant);

    // Next-state and accept logic. req_ready is raised only in IDLE and only
    // for the granted client, so a handshake is simply "IDLE with a grant".
    // rsp_ready never feeds req_ready: a completing response returns the
    // FSM to IDLE first and the next grant happens a cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_req_ready[w_grant_id] = 1'b1;
                    w_hs                    = 1'b1;
                    w_state_nxt             = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control: state, round-robin history and the registered response valid.
    // last_grant resets to client 1 so client 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (w_hs) begin
                r_last_grant <= w_grant_id;
            end
        end
    end

    // Issue stage: the granted client's operands and opcode are latched onto
    // the ALU inputs at the handshake and held until the next handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a  <= 8'h00;
            r_alu_b  <= 8'h00;
            r_alu_s  <= 3'b000;
            r_rsp_id <= 1'b0;
        end else if (w_hs) begin
            r_alu_a  <= w_grant_id ? req1_a : req0_a;
            r_alu_b  <= w_grant_id ? req1_b : req0_b;
            r_alu_s  <= w_grant_id ? req1_s : req0_s;
            r_rsp_id <= w_grant_id;
        end
    end

    // Capture stage: the ALU has had a full cycle to settle on the issued
    // operands; its result is sampled once in EXEC and held through RESP.
    // A reset in EXEC or RESP clears it, so an in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_z    <= 8'h00;
            r_rsp_zero <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_z    <= alu_z;
            r_rsp_zero <= (alu_z == 8'h00);
        end
    end

    assign req_ready = w_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_z     = r_rsp_z;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. The shared ALU is modelled here as a
// plain arithmetic function. Directed scenarios cover reset, single ops,
// wrap/preset/clear opcodes, contention, backpressure and reset mid-op. A
// randomized run is checked against a transaction-level model (grant rule,
// in-flight transaction and its age in cycles).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_s, req1_s;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_z;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [7:0] rsp_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_s    (req0_s),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_s    (req1_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_zero  (rsp_zero)
    );

    // Opcode table with modulo-256 integer arithmetic.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s);
        int r;
        case (s)
            3'd0:    r = 0;
            3'd1:    r = int'(b) - int'(a);
            3'd2:    r = int'(a) - int'(b);
            3'd3:    r = int'(a) + int'(b);
            3'd4:    r = int'(a ^ b);
            3'd5:    r = int'(a | b);
            3'd6:    r = int'(a & b);
            default: r = 255;
        endcase
        return r[7:0];
    endfunction

    // The shared ALU itself: combinational from the registered DUT outputs.
    always_comb alu_z = alu_ref(alu_a, alu_b, alu_s);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] s);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_s = s;
        end else begin
            req1_a = a; req1_b = b; req1_s = s;
        end
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_rsp(input int max_cyc, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < max_cyc) begin
            tick();
            lat++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
    endtask

    // Issue one op from an idle arbiter, collect its response, then accept it.
    task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] s, output bit seen, output logic [7:0] z,
                          output logic zid, output logic zero);
        int lat;
        drive_req(id, a, b, s);
        tick();
        req_valid = 2'b00;
        wait_rsp(8, lat, seen);
        z    = rsp_z;
        zid  = rsp_id;
        zero = rsp_zero;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req0_a = 8'h00; req0_b = 8'h00; req0_s = 3'b000;
        req1_a = 8'h00; req1_b = 8'h00; req1_s = 3'b000;
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rsp_flags got valid=%0b id=%0b zero=%0b want 0 0 0",
                     rsp_valid, rsp_id, rsp_zero);
        end
        checks++;
        if (rsp_z !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp_z got %h want 00", rsp_z);
        end
        checks++;
        if ({alu_a, alu_b, alu_s} !== 19'd0) begin
            errors++;
            $display("FAIL reset_alu got a=%h b=%h s=%b want 00 00 000", alu_a, alu_b, alu_s);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 00", req_ready);
        end
    endtask

    task automatic test_single_op();
        int lat;
        bit seen;
        do_reset();
        drive_req(1'b0, 8'h05, 8'h03, 3'b010);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_req_ready got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid got %b want 0", rsp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_s} !== {8'h05, 8'h03, 3'b010}) begin
            errors++;
            $display("FAIL single_alu_in got a=%h b=%h s=%b want 05 03 010", alu_a, alu_b, alu_s);
        end
        // Handshake at edge T; rsp_valid is first seen right after edge T+1,
        // i.e. it is high when sampled by edge T+2.
        wait_rsp(8, lat, seen);
        checks++;
        if (!seen || lat != 1) begin
            errors++;
            $display("FAIL single_latency got seen=%0b lat=%0d want seen=1 lat=1", seen, lat);
        end
        checks++;
        if ({rsp_z, rsp_id, rsp_zero} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp got z=%h id=%b zero=%b want 02 0 0", rsp_z, rsp_id, rsp_zero);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_done got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_wrap_preset();
        bit seen;
        logic [7:0] z;
        logic zid, zero;
        do_reset();
        run_op(1'b1, 8'h05, 8'h03, 3'b001, seen, z, zid, zero);
        checks++;
        if (!seen || {z, zid, zero} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_sub got seen=%0b z=%h id=%b zero=%b want 1 FE 1 0", seen, z, zid, zero);
        end
        run_op(1'b1, 8'h80, 8'h80, 3'b011, seen, z, zid, zero);
        checks++;
        if (!seen || {z, zid, zero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_add got seen=%0b z=%h id=%b zero=%b want 1 00 1 1", seen, z, zid, zero);
        end
        run_op(1'b0, 8'h12, 8'h34, 3'b111, seen, z, zid, zero);
        checks++;
        if (!seen || {z, zid, zero} !== {8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL preset got seen=%0b z=%h id=%b zero=%b want 1 FF 0 0", seen, z, zid, zero);
        end
    endtask

    task automatic test_clear();
        bit seen;
        logic [7:0] z;
        logic zid, zero;
        do_reset();
        run_op(1'b0, 8'hAA, 8'h55, 3'b000, seen, z, zid, zero);
        checks++;
        if (!seen || {z, zid, zero} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL clear got seen=%0b z=%h id=%b zero=%b want 1 00 0 1", seen, z, zid, zero);
        end
    endtask

    task automatic test_contention();
        bit         last_m;
        bit         g;
        bit         exp_q[$];
        logic [7:0] expz_q[$];
        int         hs_cyc[$];
        int         grants;
        grants = 0;
        do_reset();
        last_m = 1'b1;
        req0_a = 8'h01; req0_b = 8'h02; req0_s = 3'b011;
        req1_a = 8'hF0; req1_b = 8'hFF; req1_s = 3'b100;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            checks++;
            if (req_ready === 2'b11) begin
                errors++;
                $display("FAIL contention_both_ready got %b at cycle %0d", req_ready, cyc);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL contention_spurious_rsp got id=%b z=%h want none", rsp_id, rsp_z);
                end else begin
                    if (rsp_id !== exp_q[0] || rsp_z !== expz_q[0]) begin
                        errors++;
                        $display("FAIL contention_rsp got id=%b z=%h want id=%b z=%h",
                                 rsp_id, rsp_z, exp_q[0], expz_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(expz_q.pop_front());
                end
            end
            if (req_ready !== 2'b00) begin
                g = ~last_m;
                checks++;
                if (req_ready !== (g ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention_grant got %b want client %0d", req_ready, g);
                end
                if (hs_cyc.size() > 0) begin
                    checks++;
                    if (cyc - hs_cyc[$] != 3) begin
                        errors++;
                        $display("FAIL contention_rate got gap %0d want 3", cyc - hs_cyc[$]);
                    end
                end
                exp_q.push_back(g);
                expz_q.push_back(g ? 8'h0F : 8'h03);
                hs_cyc.push_back(cyc);
                last_m = g;
                grants++;
            end
            tick();
        end
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 6 && exp_q.size() > 0; cyc++) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_id !== exp_q[0] || rsp_z !== expz_q[0]) begin
                    errors++;
                    $display("FAIL contention_last_rsp got id=%b z=%h want id=%b z=%h",
                             rsp_id, rsp_z, exp_q[0], expz_q[0]);
                end
                void'(exp_q.pop_front());
                void'(expz_q.pop_front());
            end
            tick();
        end
        checks++;
        if (grants != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL contention_count got grants=%0d pending=%0d want 4 0", grants, exp_q.size());
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        bit seen;
        logic [7:0] z0, a0, b0;
        logic [2:0] s0;
        logic id0;
        do_reset();
        drive_req(1'b0, 8'h10, 8'h22, 3'b011);
        tick();
        req_valid = 2'b00;
        drive_req(1'b1, 8'h07, 8'h09, 3'b110);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_ready_exec got %b want 00", req_ready);
        end
        wait_rsp(8, lat, seen);
        checks++;
        if (!seen || rsp_z !== 8'h32 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_rsp got seen=%0b z=%h id=%b want 1 32 0", seen, rsp_z, rsp_id);
        end
        z0 = rsp_z; id0 = rsp_id; a0 = alu_a; b0 = alu_b; s0 = alu_s;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_z !== z0 || rsp_id !== id0 ||
                alu_a !== a0 || alu_b !== b0 || alu_s !== s0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold got v=%b z=%h id=%b a=%h b=%h s=%b rdy=%b want 1 %h %b %h %h %b 00",
                         rsp_valid, rsp_z, rsp_id, alu_a, alu_b, alu_s, req_ready, z0, id0, a0, b0, s0);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_no_bypass got %b want 00", req_ready);
        end
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10 || alu_a !== 8'h10) begin
            errors++;
            $display("FAIL bp_after_rsp got v=%b rdy=%b a=%h want 0 10 10", rsp_valid, req_ready, alu_a);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if ({alu_a, alu_b, alu_s, rsp_id} !== {8'h07, 8'h09, 3'b110, 1'b1}) begin
            errors++;
            $display("FAIL bp_second_issue got a=%h b=%h s=%b id=%b want 07 09 110 1",
                     alu_a, alu_b, alu_s, rsp_id);
        end
        wait_rsp(8, lat, seen);
        checks++;
        if (!seen || rsp_z !== 8'h01 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_rsp got seen=%0b z=%h id=%b want 1 01 1", seen, rsp_z, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int lat;
        bit seen;
        bit any_valid;
        do_reset();
        // Reset while in EXEC.
        drive_req(1'b0, 8'h11, 8'h22, 3'b011);
        tick();
        req_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_z, rsp_zero, alu_a, alu_b, alu_s} !== 30'd0) begin
            errors++;
            $display("FAIL rst_exec_outputs got v=%b id=%b z=%h zero=%b a=%h b=%h s=%b want all 0",
                     rsp_valid, rsp_id, rsp_z, rsp_zero, alu_a, alu_b, alu_s);
        end
        any_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) any_valid = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (any_valid) begin
            errors++;
            $display("FAIL rst_exec_dropped got a response want none");
        end
        // Reset while in RESP.
        drive_req(1'b0, 8'h33, 8'h44, 3'b011);
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_z !== 8'h77) begin
            errors++;
            $display("FAIL rst_resp_setup got v=%b z=%h want 1 77", rsp_valid, rsp_z);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_z, rsp_zero, alu_a, alu_b, alu_s} !== 30'd0) begin
            errors++;
            $display("FAIL rst_resp_outputs got v=%b id=%b z=%h zero=%b a=%h b=%h s=%b want all 0",
                     rsp_valid, rsp_id, rsp_z, rsp_zero, alu_a, alu_b, alu_s);
        end
        // Client 0 last won before reset; after reset it must still win first.
        req0_a = 8'h21; req0_b = 8'h01; req0_s = 3'b010;
        req1_a = 8'h55; req1_b = 8'h0F; req1_s = 3'b101;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_first_grant got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        wait_rsp(8, lat, seen);
        checks++;
        if (!seen || rsp_id !== 1'b0 || rsp_z !== 8'h20) begin
            errors++;
            $display("FAIL rst_first_rsp got seen=%0b id=%b z=%h want 1 0 20", seen, rsp_id, rsp_z);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit         inflight;
        int         age;
        bit         last_m;
        bit         g;
        bit         hs;
        bit         done;
        bit         exp_id;
        logic [7:0] exp_a, exp_b, exp_z;
        logic [2:0] exp_s;
        logic [1:0] exp_ready;
        int         ops;
        inflight = 1'b0;
        age      = 0;
        last_m   = 1'b1;
        ops      = 0;
        exp_id = 1'b0; exp_a = 8'h00; exp_b = 8'h00; exp_s = 3'b000; exp_z = 8'h00;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_s = 3'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_s = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = 2'b00;
            g = 1'b0;
            if (!inflight && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? ~last_m : req_valid[1];
                exp_ready = g ? 2'b10 : 2'b01;
            end
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_req_ready cyc %0d got %b want %b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (rsp_valid !== (inflight && age >= 1)) begin
                errors++;
                $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, rsp_valid, (inflight && age >= 1));
            end
            if (inflight) begin
                checks++;
                if ({alu_a, alu_b, alu_s} !== {exp_a, exp_b, exp_s}) begin
                    errors++;
                    $display("FAIL rand_alu_in cyc %0d got %h %h %b want %h %h %b",
                             cyc, alu_a, alu_b, alu_s, exp_a, exp_b, exp_s);
                end
            end
            if (inflight && age >= 1) begin
                checks++;
                if (rsp_id !== exp_id || rsp_z !== exp_z || rsp_zero !== (exp_z == 8'h00)) begin
                    errors++;
                    $display("FAIL rand_rsp cyc %0d got id=%b z=%h zero=%b want id=%b z=%h",
                             cyc, rsp_id, rsp_z, rsp_zero, exp_id, exp_z);
                end
            end
            hs   = (exp_ready != 2'b00);
            done = inflight && age >= 1 && rsp_ready;
            if (hs) begin
                exp_id = g;
                exp_a  = g ? req1_a : req0_a;
                exp_b  = g ? req1_b : req0_b;
                exp_s  = g ? req1_s : req0_s;
                exp_z  = alu_ref(exp_a, exp_b, exp_s);
            end
            tick();
            if (done) inflight = 1'b0;
            else if (inflight) age++;
            if (hs) begin
                inflight = 1'b1;
                age      = 0;
                last_m   = g;
                ops++;
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        checks++;
        if (ops < 50) begin
            errors++;
            $display("FAIL rand_throughput got %0d ops want at least 50", ops);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap_preset();
        test_clear();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
